evm_multi: RTL and testbench
============================

Name: evm_multi

Overview:
- Parametrised successor to the fixed three-candidate voting machine.
- Supports NUM_CAND candidates with CNT_W-bit saturating tallies.
- One-vote-per-voter arming handshake, with rejection of multi-hot ballots.
- Sequential winner scan with tie detection, and result readback of any candidate by index.
- Sits directly behind the tt_um_* pin wrapper; all inputs are already synchronised.

Parameters:
- NUM_CAND, 4, number of candidates (2..16); ID_W = clog2(NUM_CAND) is a derived localparam, minimum 1.
- CNT_W, 8, width of each vote counter; counters saturate at 2^CNT_W-1.
- TIMEOUT_CYC, 1000, idle cycles in ARMED before the ballot is revoked (used only with EVM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- switch_on_evm  in  1  level; low forces OFF state
- candidate_ready  in  1  officer arms one ballot; rising edge detected internally
- vote  in  NUM_CAND  voter buttons, one bit per candidate
- voting_session_done  in  1  level; closes polling
- display_results  in  1  level; drives results with tally of display_sel
- display_sel  in  ID_W  candidate index to read back
- display_winner  in  1  level; drives results with winner's tally
- results  out  CNT_W  tally readback
- candidate_name  out  ID_W  winner index (display_winner) or display_sel echo
- vote_accepted  out  1  one-cycle pulse per counted vote
- invalid_vote  out  1  one-cycle pulse on rejected ballot
- tie  out  1  high in DONE when two or more candidates share the maximum
- voting_in_progress  out  1  high in IDLE/ARMED/LOCK
- voting_done  out  1  high in DONE

Behaviour:
- Reset: state OFF; all counters 0; all outputs 0; winner register 0; tie 0.
- FSM states:
  - OFF -> IDLE when switch_on_evm=1.
  - IDLE -> ARMED on a candidate_ready rising edge.
  - ARMED -> LOCK on the first cycle where vote != 0:
    - exactly one bit set: that counter +1 (held if already saturated), vote_accepted pulses the next cycle.
    - more than one bit set: no count, invalid_vote pulses the next cycle.
  - LOCK -> IDLE once vote == 0 (buttons released). A held button never counts twice.
  - IDLE or ARMED -> SCAN when voting_session_done=1. An armed but unused ballot is discarded.
  - SCAN: one candidate compared per cycle, index 0..NUM_CAND-1, so exactly NUM_CAND cycles.
    - The winner is the lowest index among those holding the strict maximum.
    - tie is set if any later candidate equals the running maximum.
  - SCAN -> DONE after the last index. DONE holds until rst or switch_on_evm=0.
- switch_on_evm=0 in any state -> OFF next cycle; counters are retained. Only rst clears counters.
- voting_session_done is ignored in LOCK. The transition to SCAN occurs after the return to IDLE.
- Simultaneous candidate_ready edge and voting_session_done in IDLE: session_done wins.
- candidate_ready edges in ARMED, LOCK, SCAN or DONE are ignored.
- results/candidate_name are registered (1-cycle latency from select change) and are valid only in DONE.
  - display_winner has priority over display_results.
  - Neither asserted: results = 0, candidate_name = 0.
  - Outside DONE: results = 0.
- display_sel >= NUM_CAND: results = 0 and invalid_vote pulses once per new out-of-range select.
- All-zero tallies at SCAN: winner = 0, tie = 1 (for NUM_CAND >= 2).
- rst mid-SCAN or mid-ARMED: immediate return to OFF with all counters cleared.

Optional Feature:
- Macro: EVM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ARMED.
  - After TIMEOUT_CYC cycles with vote == 0, the ballot is revoked: ARMED -> IDLE, invalid_vote pulses once.
  - The counter clears on entering ARMED.
- Undefined: ARMED waits indefinitely; no timeout counter is synthesised.

Test Plan:
- Reset, switch on, 3 ballots for candidate 2 (NUM_CAND=4), close, display_winner -> after 4 SCAN cycles voting_done=1, candidate_name=2, results=3, tie=0.
- Arm, hold vote=4'b0001 for 20 cycles, release, arm, vote 4'b0001 -> tally[0]=2 and two vote_accepted pulses, not 21.
- Arm, vote=4'b0110 -> invalid_vote one pulse, all tallies unchanged, FSM returns to IDLE after release.
- CNT_W=2, 5 votes for candidate 1 -> display_sel=1 reads results=3 (saturated); vote_accepted still pulses 5 times.
- Candidates 1 and 3 get 2 votes each, close -> winner 1, tie=1; display_sel=5 (NUM_CAND=4) -> results=0, invalid_vote pulse.
- EVM_TIMEOUT_EN, TIMEOUT_CYC=10: arm, no vote for 10 cycles -> invalid_vote pulse, state IDLE. Re-arm, vote at cycle 5 -> counted.

Source files
------------

// File: rtl/evm_multi.sv
// evm_multi: NUM_CAND-candidate voting machine with saturating tallies, winner scan and readback.
// Define EVM_TIMEOUT_EN to revoke an armed ballot after TIMEOUT_CYC idle cycles.
module evm_multi #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000,
  localparam int ID_W       = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                switch_on_evm,
  input  logic                candidate_ready,
  input  logic [NUM_CAND-1:0] vote,
  input  logic                voting_session_done,
  input  logic                display_results,
  input  logic [ID_W-1:0]     display_sel,
  input  logic                display_winner,
  output logic [CNT_W-1:0]    results,
  output logic [ID_W-1:0]     candidate_name,
  output logic                vote_accepted,
  output logic                invalid_vote,
  output logic                tie,
  output logic                voting_in_progress,
  output logic                voting_done
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [ID_W-1:0]  LastIdx = ID_W'(NUM_CAND - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_ARMED,
    S_LOCK,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] tally_q [NUM_CAND];
  logic [ID_W-1:0]  scanIdx_q;
  logic [ID_W-1:0]  winner_q;
  logic [CNT_W-1:0] maxVal_q;
  logic             tie_q;
  logic             crPrev_q;
  logic             voteAcc_q;
  logic             invVote_q;
  logic [CNT_W-1:0] results_q;
  logic [ID_W-1:0]  candName_q;
  logic             oorHeld_q;
  logic [ID_W-1:0]  oorSel_q;

`ifdef EVM_TIMEOUT_EN
  localparam int TmrW = $clog2(TIMEOUT_CYC + 1);
  logic [TmrW-1:0] armTmr_q;
`endif

  logic             crEdge;
  logic             voteAny;
  logic             voteMulti;
  logic             selInRange;
  logic [ID_W-1:0]  voteIdx;
  logic [CNT_W-1:0] selTally;
  logic [CNT_W-1:0] winTally;
  logic [CNT_W-1:0] scanTally;

  // Clearing the lowest set bit leaves a nonzero value only for multi-hot ballots.
  always_comb begin
    crEdge    = candidate_ready & ~crPrev_q;
    voteAny   = |vote;
    voteMulti = |(vote & (vote - NUM_CAND'(1)));
    voteIdx   = '0;
    selTally  = '0;
    winTally  = '0;
    scanTally = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote[i]) voteIdx = ID_W'(i);
      if (display_sel == ID_W'(i)) selTally = tally_q[i];
      if (winner_q == ID_W'(i)) winTally = tally_q[i];
      if (scanIdx_q == ID_W'(i)) scanTally = tally_q[i];
    end
    selInRange = int'(display_sel) < NUM_CAND;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OFF;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      scanIdx_q  <= '0;
      winner_q   <= '0;
      maxVal_q   <= '0;
      tie_q      <= 1'b0;
      crPrev_q   <= 1'b0;
      voteAcc_q  <= 1'b0;
      invVote_q  <= 1'b0;
      results_q  <= '0;
      candName_q <= '0;
      oorHeld_q  <= 1'b0;
      oorSel_q   <= '0;
`ifdef EVM_TIMEOUT_EN
      armTmr_q   <= '0;
`endif
    end else begin
      crPrev_q  <= candidate_ready;
      voteAcc_q <= 1'b0;
      invVote_q <= 1'b0;

      if (!switch_on_evm) begin
        state_q <= S_OFF;
      end else begin
        case (state_q)
          S_OFF: state_q <= S_IDLE;

          S_IDLE: begin
            if (voting_session_done) begin
              state_q   <= S_SCAN;
              scanIdx_q <= '0;
            end else if (crEdge) begin
              state_q  <= S_ARMED;
`ifdef EVM_TIMEOUT_EN
              armTmr_q <= '0;
`endif
            end
          end

          S_ARMED: begin
            if (voting_session_done) begin
              state_q   <= S_SCAN;
              scanIdx_q <= '0;
            end else if (voteAny) begin
              state_q <= S_LOCK;
              if (voteMulti) begin
                invVote_q <= 1'b1;
              end else begin
                voteAcc_q <= 1'b1;
                for (int i = 0; i < NUM_CAND; i++)
                  if (voteIdx == ID_W'(i) && tally_q[i] != CntMax)
                    tally_q[i] <= tally_q[i] + CNT_W'(1);
              end
            end
`ifdef EVM_TIMEOUT_EN
            else if (armTmr_q == TmrW'(TIMEOUT_CYC - 1)) begin
              state_q   <= S_IDLE;
              invVote_q <= 1'b1;
            end else begin
              armTmr_q <= armTmr_q + TmrW'(1);
            end
`endif
          end

          S_LOCK: if (!voteAny) state_q <= S_IDLE;

          // Index 0 seeds the running maximum; a strictly larger tally takes over and clears tie.
          S_SCAN: begin
            if (scanIdx_q == '0 || scanTally > maxVal_q) begin
              maxVal_q <= scanTally;
              winner_q <= scanIdx_q;
              tie_q    <= 1'b0;
            end else if (scanTally == maxVal_q) begin
              tie_q <= 1'b1;
            end
            if (scanIdx_q == LastIdx) state_q <= S_DONE;
            else scanIdx_q <= scanIdx_q + ID_W'(1);
          end

          S_DONE: state_q <= S_DONE;

          default: state_q <= S_OFF;
        endcase
      end

      if (state_q == S_DONE && display_winner) begin
        results_q  <= winTally;
        candName_q <= winner_q;
      end else if (state_q == S_DONE && display_results) begin
        results_q  <= selInRange ? selTally : '0;
        candName_q <= display_sel;
      end else begin
        results_q  <= '0;
        candName_q <= '0;
      end

      // An out-of-range select flags once, and again only when a different bad index appears.
      if (state_q == S_DONE && !selInRange) begin
        if (!oorHeld_q || oorSel_q != display_sel) invVote_q <= 1'b1;
        oorHeld_q <= 1'b1;
        oorSel_q  <= display_sel;
      end else begin
        oorHeld_q <= 1'b0;
      end
    end
  end

  assign results            = results_q;
  assign candidate_name     = candName_q;
  assign vote_accepted      = voteAcc_q;
  assign invalid_vote       = invVote_q;
  assign tie                = tie_q & (state_q == S_DONE);
  assign voting_in_progress = (state_q == S_IDLE) || (state_q == S_ARMED) || (state_q == S_LOCK);
  assign voting_done        = (state_q == S_DONE);

endmodule

// File: tb/tb_evm_multi.sv
// tb_evm_multi: directed plus randomized ballots for evm_multi, checked against a tally model.
module tb_evm_multi;

  localparam int NC   = 5;
  localparam int CW   = 3;
  localparam int IW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          switch_on_evm = 1'b0;
  logic          candidate_ready = 1'b0;
  logic [NC-1:0] vote = '0;
  logic          voting_session_done = 1'b0;
  logic          display_results = 1'b0;
  logic [IW-1:0] display_sel = '0;
  logic          display_winner = 1'b0;
  logic [CW-1:0] results;
  logic [IW-1:0] candidate_name;
  logic          vote_accepted;
  logic          invalid_vote;
  logic          tie;
  logic          voting_in_progress;
  logic          voting_done;

  evm_multi #(.NUM_CAND(NC), .CNT_W(CW), .TIMEOUT_CYC(10)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .switch_on_evm       (switch_on_evm),
    .candidate_ready     (candidate_ready),
    .vote                (vote),
    .voting_session_done (voting_session_done),
    .display_results     (display_results),
    .display_sel         (display_sel),
    .display_winner      (display_winner),
    .results             (results),
    .candidate_name      (candidate_name),
    .vote_accepted       (vote_accepted),
    .invalid_vote        (invalid_vote),
    .tie                 (tie),
    .voting_in_progress  (voting_in_progress),
    .voting_done         (voting_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int tally[NC];
  int expAcc = 0;
  int expInv = 0;
  int accCount = 0;
  int invCount = 0;
  int scanCyc;

  // Pulse totals, sampled on the edge so each one-cycle pulse is seen exactly once.
  always @(posedge clk) begin
    accCount <= accCount + int'(vote_accepted);
    invCount <= invCount + int'(invalid_vote);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed hang required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  function automatic void modelVote(input logic [NC-1:0] v);
    if ($countones(v) == 1) begin
      for (int i = 0; i < NC; i++)
        if (v[i] && tally[i] < MAXC) tally[i]++;
      expAcc++;
    end else begin
      expInv++;
    end
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < NC; i++) tally[i] = 0;
  endfunction

  task automatic castBallot(input logic [NC-1:0] v, input int hold);
    candidate_ready = 1'b1;
    applyStimulus(1);
    candidate_ready = 1'b0;
    vote = v;
    applyStimulus(1);
    modelVote(v);
    checkOutput("acceptPulse", vote_accepted, ($countones(v) == 1));
    checkOutput("invalidPulse", invalid_vote, ($countones(v) != 1));
    applyStimulus(hold);
    vote = '0;
    applyStimulus(1);
  endtask

  task automatic checkCounts();
    applyStimulus(2);
    checkOutput("acceptCount", accCount, expAcc);
    checkOutput("invalidCount", invCount, expInv);
  endtask

  task automatic closeAndScan();
    int guard;
    guard = 0;
    scanCyc = 0;
    voting_session_done = 1'b1;
    while (voting_done !== 1'b1 && guard < 60) begin
      applyStimulus(1);
      guard++;
      if (!voting_in_progress && !voting_done) scanCyc++;
    end
    voting_session_done = 1'b0;
    candidate_ready = 1'b0;
    checkOutput("doneReached", voting_done, 1);
    checkOutput("scanCycles", scanCyc, NC);
  endtask

  task automatic checkAll();
    int mx, w, ties;
    mx = 0;
    for (int i = 0; i < NC; i++) if (tally[i] > mx) mx = tally[i];
    w = -1;
    ties = 0;
    for (int i = 0; i < NC; i++)
      if (tally[i] == mx) begin
        if (w < 0) w = i;
        ties++;
      end
    checkOutput("tie", tie, (ties > 1));
    display_winner = 1'b1;
    applyStimulus(1);
    checkOutput("winnerName", candidate_name, w);
    checkOutput("winnerTally", results, mx);
    display_winner = 1'b0;
    display_results = 1'b1;
    for (int i = 0; i < NC; i++) begin
      display_sel = IW'(i);
      applyStimulus(1);
      checkOutput($sformatf("tally%0d", i), results, tally[i]);
      checkOutput($sformatf("selEcho%0d", i), candidate_name, i);
    end
    display_results = 1'b0;
    display_sel = '0;
    applyStimulus(1);
    checkOutput("noDisplayResults", results, 0);
    checkOutput("noDisplayName", candidate_name, 0);
  endtask

  task automatic powerCycle();
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    modelClear();
    switch_on_evm = 1'b1;
    applyStimulus(1);
  endtask

  initial begin
    modelClear();
    applyStimulus(3);
    checkOutput("rstResults", results, 0);
    checkOutput("rstName", candidate_name, 0);
    checkOutput("rstAccept", vote_accepted, 0);
    checkOutput("rstInvalid", invalid_vote, 0);
    checkOutput("rstTie", tie, 0);
    checkOutput("rstInProgress", voting_in_progress, 0);
    checkOutput("rstDone", voting_done, 0);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("offInProgress", voting_in_progress, 0);
    switch_on_evm = 1'b1;
    applyStimulus(1);
    checkOutput("onInProgress", voting_in_progress, 1);

    $display("[TB] session A: directed ballots");
    for (int k = 0; k < 3; k++) castBallot(5'b00100, 0);
    castBallot(5'b00001, 20);
    castBallot(5'b00001, 0);
    castBallot(5'b00110, 2);
    checkOutput("idleAfterInvalid", voting_in_progress, 1);
    checkCounts();

`ifdef EVM_TIMEOUT_EN
    candidate_ready = 1'b1;
    applyStimulus(1);
    candidate_ready = 1'b0;
    applyStimulus(9);
    checkOutput("noEarlyTimeout", invalid_vote, 0);
    applyStimulus(1);
    checkOutput("timeoutPulse", invalid_vote, 1);
    expInv++;
    vote = 5'b01000;
    applyStimulus(1);
    checkOutput("revokedNoCount", vote_accepted, 0);
    vote = '0;
    applyStimulus(1);
    candidate_ready = 1'b1;
    applyStimulus(1);
    candidate_ready = 1'b0;
    applyStimulus(4);
    vote = 5'b01000;
    applyStimulus(1);
    modelVote(5'b01000);
    checkOutput("lateVoteCounted", vote_accepted, 1);
    vote = '0;
    applyStimulus(1);
`else
    candidate_ready = 1'b1;
    applyStimulus(1);
    candidate_ready = 1'b0;
    applyStimulus(30);
    checkOutput("armedWaits", voting_in_progress, 1);
    checkOutput("armedNoInvalid", invalid_vote, 0);
    vote = 5'b01000;
    applyStimulus(1);
    modelVote(5'b01000);
    checkOutput("lateVoteCounted", vote_accepted, 1);
    vote = '0;
    applyStimulus(1);
`endif

    // A ready edge during LOCK must not arm a further ballot.
    candidate_ready = 1'b1;
    applyStimulus(1);
    candidate_ready = 1'b0;
    vote = 5'b10000;
    applyStimulus(1);
    modelVote(5'b10000);
    checkOutput("lockVote", vote_accepted, 1);
    candidate_ready = 1'b1;
    applyStimulus(2);
    vote = '0;
    applyStimulus(2);
    vote = 5'b10000;
    applyStimulus(1);
    checkOutput("lockEdgeIgnored", vote_accepted, 0);
    vote = '0;
    candidate_ready = 1'b0;
    applyStimulus(1);

    display_results = 1'b1;
    display_sel = 3'd2;
    applyStimulus(1);
    checkOutput("resultsOutsideDone", results, 0);
    display_results = 1'b0;

    candidate_ready = 1'b1;
    applyStimulus(1);
    candidate_ready = 1'b0;
    vote = 5'b00010;
    applyStimulus(1);
    modelVote(5'b00010);
    voting_session_done = 1'b1;
    applyStimulus(3);
    checkOutput("doneIgnoredInLock", voting_in_progress, 1);
    vote = '0;
    closeAndScan();
    checkAll();
    checkCounts();

    $display("[TB] session B: counters survive power off");
    switch_on_evm = 1'b0;
    applyStimulus(1);
    checkOutput("offFromDone", voting_done, 0);
    switch_on_evm = 1'b1;
    applyStimulus(1);
    closeAndScan();
    checkAll();

    $display("[TB] session C: reset while armed, all-zero scan");
    candidate_ready = 1'b1;
    applyStimulus(1);
    candidate_ready = 1'b0;
    rst = 1'b1;
    applyStimulus(1);
    modelClear();
    checkOutput("rstArmedOff", voting_in_progress, 0);
    rst = 1'b0;
    applyStimulus(1);
    candidate_ready = 1'b1;
    closeAndScan();
    checkAll();

    $display("[TB] session D: tie and out-of-range select");
    powerCycle();
    castBallot(5'b00010, 0);
    castBallot(5'b01000, 1);
    castBallot(5'b00010, 0);
    castBallot(5'b01000, 0);
    closeAndScan();
    checkAll();
    display_results = 1'b1;
    display_winner = 1'b1;
    display_sel = 3'd3;
    applyStimulus(1);
    checkOutput("winnerPriority", candidate_name, 1);
    display_winner = 1'b0;
    display_sel = 3'd5;
    applyStimulus(1);
    checkOutput("oorResults", results, 0);
    checkOutput("oorPulse", invalid_vote, 1);
    expInv++;
    applyStimulus(1);
    checkOutput("oorSinglePulse", invalid_vote, 0);
    display_sel = 3'd6;
    applyStimulus(1);
    checkOutput("oorNewSelPulse", invalid_vote, 1);
    expInv++;
    display_sel = 3'd3;
    applyStimulus(1);
    checkOutput("inRangeNoPulse", invalid_vote, 0);
    checkOutput("inRangeTally", results, tally[3]);
    display_results = 1'b0;
    display_sel = '0;
    checkCounts();

    $display("[TB] session E: saturation");
    powerCycle();
    for (int k = 0; k < 9; k++) castBallot(5'b00010, 0);
    checkCounts();
    closeAndScan();
    checkAll();

    $display("[TB] session F: random ballots");
    powerCycle();
    for (int k = 0; k < 25; k++)
      castBallot(NC'($urandom_range(1, (1 << NC) - 1)), $urandom_range(0, 3));
    checkCounts();
    closeAndScan();
    checkAll();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
